// File: rtl/hockey_auto_player.sv
// ============================================================================
// Module   : hockey_auto_player
// Purpose  : Autonomous player B for DigiHockey; serves/hits via BTNB, YB, DIRB.
// Options  : define MISS_INJECT_EN for LFSR-driven deliberate misses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hockey_auto_player #(
  parameter int X_HIT        = 4,
  parameter int REACT_CYCLES = 3,
  parameter int PRESS_CYCLES = 4,
  parameter int SERVE_Y      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       LEDB,
  input  logic       serve,
  input  logic [2:0] X,
  input  logic [2:0] Y,
  output logic       BTNB,
  output logic [2:0] YB,
  output logic [1:0] DIRB
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECIDE  = 3'd1,
    S_REACT   = 3'd2,
    S_PRESS   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int CNT_MAX = (REACT_CYCLES > PRESS_CYCLES) ? REACT_CYCLES : PRESS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1) + 1;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_dir_ptr;
  logic [3:0]      r_hit_cnt;

  logic [2:0]      w_y_clamp;
  logic [2:0]      w_hit_y;
  logic            w_x_match;
  logic            w_react_done;
  logic            w_press_done;

  assign w_y_clamp    = (Y > 3'd4) ? 3'd4 : Y;
  assign w_x_match    = (X == 3'(X_HIT)) && (X <= 3'd4);
  // A zero react delay still spends one REACT cycle, same as a delay of one.
  assign w_react_done = (REACT_CYCLES <= 1) || (r_cnt >= CW'(REACT_CYCLES - 1));
  assign w_press_done = (r_cnt >= CW'(PRESS_CYCLES - 1));

`ifdef MISS_INJECT_EN
  logic [4:0] r_lfsr;

  always_comb begin
    w_hit_y = w_y_clamp;
    if (r_lfsr[1:0] == 2'b00)
      w_hit_y = (w_y_clamp == 3'd4) ? 3'd0 : w_y_clamp + 3'd1;
  end

  // x^5 + x^3 + 1, stepped once per decision (serves included)
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_lfsr <= 5'b00001;
    else if (r_state == S_DECIDE)
      r_lfsr <= {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  end
`else
  assign w_hit_y = w_y_clamp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dir_ptr <= 2'd0;
      r_hit_cnt <= 4'd0;
      BTNB      <= 1'b0;
      YB        <= 3'd0;
      DIRB      <= 2'b00;
    end else if (!en) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      BTNB    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          BTNB <= 1'b0;
          if (LEDB && serve) begin
            YB      <= 3'(SERVE_Y);
            r_state <= S_DECIDE;
          end else if (LEDB && w_x_match) begin
            YB      <= w_hit_y;
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          DIRB    <= r_dir_ptr;
          r_cnt   <= '0;
          r_state <= S_REACT;
        end
        S_REACT: begin
          if (!LEDB) begin
            r_state <= S_IDLE;
          end else if (w_react_done) begin
            r_cnt   <= '0;
            BTNB    <= 1'b1;
            r_state <= S_PRESS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PRESS: begin
          if (w_press_done) begin
            r_cnt <= '0;
            BTNB  <= 1'b0;
            if (LEDB) begin
              r_state <= S_RELEASE;
            end else begin
              // Window already closed: the press counts as a completed shot.
              r_state   <= S_IDLE;
              r_dir_ptr <= (r_dir_ptr == 2'd2) ? 2'd0 : r_dir_ptr + 2'd1;
              r_hit_cnt <= r_hit_cnt + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (!LEDB) begin
            r_state   <= S_IDLE;
            r_dir_ptr <= (r_dir_ptr == 2'd2) ? 2'd0 : r_dir_ptr + 2'd1;
            r_hit_cnt <= r_hit_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hockey_auto_player.sv
// ============================================================================
// Module   : tb_hockey_auto_player
// Purpose  : Directed self-checking bench for hockey_auto_player (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hockey_auto_player;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       LEDB;
  logic       serve;
  logic [2:0] X;
  logic [2:0] Y;
  logic       BTNB;
  logic [2:0] YB;
  logic [1:0] DIRB;

  int checks   = 0;
  int failures = 0;

  int b [1:12];
  int yb1;
  int dirb2;

  hockey_auto_player dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .LEDB  (LEDB),
    .serve (serve),
    .X     (X),
    .Y     (Y),
    .BTNB  (BTNB),
    .YB    (YB),
    .DIRB  (DIRB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 1; i <= 12; i++) b[i] = 0;
    yb1   = -1;
    dirb2 = -1;
  endtask

  // Index 1 is the cycle right after the triggering inputs are sampled.
  task automatic rec(input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      tick();
      b[i] = int'(BTNB);
      if (i == 1) yb1 = int'(YB);
      if (i == 2) dirb2 = int'(DIRB);
    end
  endtask

  function automatic int ones();
    int n = 0;
    for (int i = 1; i <= 12; i++) n += b[i];
    return n;
  endfunction

  function automatic int first_hi();
    for (int i = 1; i <= 12; i++) if (b[i] == 1) return i;
    return 0;
  endfunction

  // Puck walks across the board; X reaches the hit column on the last step.
  task automatic approach(input logic [2:0] yv);
    serve = 1'b0;
    LEDB  = 1'b1;
    Y     = yv;
    for (int x = 0; x < 4; x++) begin
      X = 3'(x);
      tick();
    end
    X = 3'd4;
  endtask

  task automatic close_window();
    LEDB = 1'b0;
    X    = 3'd0;
    tick();
    tick();
  endtask

  initial begin
    int extra;
    rst = 1'b1; en = 1'b1; LEDB = 1'b0; serve = 1'b0; X = 3'd0; Y = 3'd0;
    tick();
    tick();
    chk("reset_btnb", int'(BTNB), 0);
    chk("reset_yb",   int'(YB),   0);
    chk("reset_dirb", int'(DIRB), 0);
    rst = 1'b0;
    tick();

    // Serve held open for 50 cycles: exactly one press.
    serve = 1'b1; LEDB = 1'b1;
    clr();
    rec(1, 12);
    chk("serve_yb",       yb1,      2);
    chk("serve_dirb",     dirb2,    0);
    chk("serve_btnb_t4",  b[4],     0);
    chk("serve_first_hi", first_hi(), 5);
    chk("serve_len",      ones(),   4);
    chk("serve_btnb_t9",  b[9],     0);
    extra = 0;
    for (int i = 13; i <= 50; i++) begin
      tick();
      extra += int'(BTNB);
    end
    chk("serve_single_press", extra, 0);
    serve = 1'b0;
    close_window();

    // Async reset mid-press.
    serve = 1'b1; LEDB = 1'b1;
    clr();
    rec(1, 6);
    chk("midpress_high", b[6], 1);
    rst = 1'b1;
    #1;
    chk("midpress_rst_btnb", int'(BTNB), 0);
    chk("midpress_rst_yb",   int'(YB),   0);
    chk("midpress_rst_dirb", int'(DIRB), 0);
    serve = 1'b0; LEDB = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_idle_btnb", int'(BTNB), 0);

    // Four hits: direction rotates 00, 01, 10, 00.
    for (int h = 0; h < 4; h++) begin
      approach(3'd3);
      clr();
      rec(1, 10);
      chk("hit_dirb", dirb2, h % 3);
      chk("hit_len",  ones(), 4);
      if (h == 0) begin
        chk("hit_yb",       yb1, 3);
        chk("hit_first_hi", first_hi(), 5);
      end
      close_window();
    end

    // Abort in REACT: no press, pointer not advanced.
    approach(3'd1);
    clr();
    rec(1, 2);
    LEDB = 1'b0;
    rec(3, 12);
    chk("abort_no_press", ones(), 0);
    chk("abort_dirb",     dirb2,  1);
    close_window();

    approach(3'd0);
    clr();
    rec(1, 10);
    chk("after_abort_dirb", dirb2, 1);
    chk("after_abort_len",  ones(), 4);
    chk("after_abort_yb",   yb1,   0);
    close_window();

    // Enable dropped during REACT.
    approach(3'd2);
    clr();
    rec(1, 2);
    en = 1'b0;
    rec(3, 12);
    chk("en_off_no_press", ones(), 0);
    LEDB = 1'b0;
    tick();
    en = 1'b1;
    close_window();

    // Row clamp; direction still at 10 since the en-off attempt did not fire.
    approach(3'd6);
    clr();
    rec(1, 10);
    chk("clamp_yb",   yb1,   4);
    chk("clamp_dirb", dirb2, 2);
    chk("clamp_len",  ones(), 4);
    close_window();

    // Off-board column never matches.
    LEDB = 1'b1; X = 3'd5; Y = 3'd1;
    clr();
    rec(1, 10);
    chk("x5_no_press", ones(), 0);
    chk("x5_yb_hold",  yb1,    4);
    close_window();

    // Serve and hit column together: serve row wins.
    serve = 1'b1; LEDB = 1'b1; X = 3'd4; Y = 3'd3;
    clr();
    rec(1, 10);
    chk("serve_wins_yb",   yb1,   2);
    chk("serve_wins_dirb", dirb2, 0);
    chk("serve_wins_len",  ones(), 4);
    serve = 1'b0;
    close_window();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
